vga_pic_bounce: RTL and testbench
=================================

// Module: vga_pic_bounce
// PURPOSE
//  Parametrised VGA timing generator with ROM-picture overlay. Draws a PIC_W x PIC_H image
//  from an external single-port ROM (1-cycle read latency) over a solid background.
//  Optionally moves the image one STEP per frame, bouncing off the active-area edges.
//  Sits between the pixel clock domain (sys_clk) and the VGA DAC pins.
// PARAMETERS
//  H_SYNC   96     hsync pulse width, pixels      | H_BACK  48   h back porch
//  H_VALID  640    h active pixels                | H_FRONT 16   h front porch
//  V_SYNC   2      vsync pulse width, lines       | V_BACK  33   v back porch
//  V_VALID  480    v active lines                 | V_FRONT 10   v front porch
//  PIC_W    100    image width, pixels (<= H_VALID) | PIC_H 100   image height (<= V_VALID)
//  ADDR_W   14     ROM address width (2^ADDR_W >= PIC_W*PIC_H)
//  RGB_W    16     pixel width (RGB565)           | BG_COLOR 16'hFFFF  background colour
//  STEP     1      motion per frame, pixels, per axis
// PORTS
//  sys_clk     in   1       pixel clock
//  sys_rst     in   1       async active-high reset
//  rom_rd_en   out  1       ROM read enable
//  rom_addr    out  ADDR_W  ROM address, row-major
//  rom_data    in   RGB_W   ROM q, valid 1 cycle after rom_rd_en/rom_addr
//  hsync       out  1       horizontal sync, active high
//  vsync       out  1       vertical sync, active high
//  vga_de      out  1       active-video flag
//  frame_end   out  1       1-cycle pulse on last pixel clock of a frame
//  vga_rgb     out  RGB_W   pixel colour
// BEHAVIOUR
//  - Reset (async, sys_rst=1): cnt_h=cnt_v=0; hsync,vsync,vga_de,frame_end,rom_rd_en=0;
//    rom_addr=0; vga_rgb=0; position/direction to reset values (see CONFIGURATION).
//    Released synchronously on next sys_clk edge; mid-frame reset restarts frame from (0,0).
//  - H_TOTAL=H_SYNC+H_BACK+H_VALID+H_FRONT (800); V_TOTAL likewise (525).
//  - cnt_h 0..H_TOTAL-1, wraps to 0; cnt_v increments when cnt_h wraps, 0..V_TOTAL-1, wraps.
//  - Active: cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1], cnt_v likewise;
//    px=cnt_h-(H_SYNC+H_BACK), py=cnt_v-(V_SYNC+V_BACK).
//  - in_pic = active && px in [pos_x,pos_x+PIC_W-1] && py in [pos_y,pos_y+PIC_H-1].
//  - Cycle t (counters at h,v): rom_rd_en=in_pic and rom_addr=(py-pos_y)*PIC_W+(px-pos_x),
//    both combinational from counters and position registers; rom_addr holds last value
//    when rom_rd_en=0.
//  - Cycle t+1 (registered): hsync=(h<H_SYNC), vsync=(v<V_SYNC), vga_de=active,
//    in_pic_d=in_pic. vga_rgb = in_pic_d ? rom_data : (vga_de ? BG_COLOR : 0).
//    Sync, de and rgb are mutually aligned; total latency from counter to pin = 1 cycle.
//  - frame_end registered: high for one cycle after cnt_h=H_TOTAL-1 && cnt_v=V_TOTAL-1.
//  - Position (pos_x,pos_y) and direction (dx,dy in {+1,-1}) change only when
//    cnt_h=H_TOTAL-1 && cnt_v=V_TOTAL-1; constant for the whole visible frame.
//  - Per axis: nx=pos_x+dx*STEP; if nx<0 or nx>H_VALID-PIC_W, dx flips and pos_x is
//    unchanged that frame; else pos_x=nx. Y identical with V_VALID-PIC_H. Corner hit:
//    both axes flip in the same frame. PIC_W=H_VALID: x never moves, dx toggles each frame.
//  - Arithmetic: counters and positions wide enough for H_TOTAL/V_TOTAL; signed compare
//    for nx<0; rom_addr truncated to ADDR_W (never exceeds PIC_W*PIC_H-1).
// CONFIGURATION
//  Macro VGA_PIC_BOUNCE_EN:
//   defined   -> motion enabled; reset pos=(0,0), dx=dy=+1.
//   undefined -> static image; pos fixed at ((H_VALID-PIC_W)/2,(V_VALID-PIC_H)/2)=(270,190)
//                by default; no direction logic; frame_end still generated.
// TESTING
//  1 Reset 20ns then release, 50MHz clk -> hsync high 96 clk of every 800; vsync high 2 lines
//    of every 525; vga_de high 640x480 per frame; frame_end once per 420000 clk.
//  2 Static build, ROM model q=addr -> first image pixel at px=270,py=190 shows 0;
//    px=369,py=289 shows 9999; px=269 or 370 shows 16'hFFFF; blanking shows 0.
//  3 BOUNCE build -> frame 0 image at (0,0), frame 1 at (1,1); frame 380 reaches y=380,
//    frame 381 y stays 380 with dy=-1, frame 382 y=379.
//  4 BOUNCE, STEP=1 -> x reaches 540 at frame 540, stays 540 at 541, returns to 0 and holds
//    one frame; position never leaves [0,540]x[0,380]; rom_addr never > 9999.
//  5 Assert sys_rst mid-line at cnt_h=400,cnt_v=200 -> all outputs 0 same cycle (async);
//    after release counting resumes from (0,0), position back to reset value.
//  6 PIC_W=H_VALID=640, PIC_H=1 -> vga_de and rom_rd_en coincide on the image line;
//    x fixed at 0, no address gaps 0..639.

Source files
------------

// File: rtl/vga_pic_bounce.sv
// VGA timing generator with ROM-picture overlay over a solid background.
// Define VGA_PIC_BOUNCE_EN to move the picture one STEP per frame, bouncing off the edges.
module vga_pic_bounce #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter int PIC_W   = 100,
    parameter int PIC_H   = 100,
    parameter int ADDR_W  = 14,
    parameter int RGB_W   = 16,
    parameter logic [RGB_W-1:0] BG_COLOR = 16'hFFFF,
    parameter int STEP    = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [RGB_W-1:0]  rom_data,
    output logic              hsync,
    output logic              vsync,
    output logic              vga_de,
    output logic              frame_end,
    output logic [RGB_W-1:0]  vga_rgb
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    logic [HW-1:0]     cnt_h;
    logic [VW-1:0]     cnt_v;
    logic              h_last;
    logic              frame_last;
    logic              h_act;
    logic              v_act;
    logic [HW-1:0]     px;
    logic [VW-1:0]     py;
    logic [HW-1:0]     pos_x;
    logic [VW-1:0]     pos_y;
    logic              pic_x;
    logic              pic_y;
    logic              in_pic;
    logic              in_pic_d;
    logic [ADDR_W-1:0] addr_c;
    logic [ADDR_W-1:0] addr_hold;

    assign h_last     = (cnt_h == HW'(H_TOTAL - 1));
    assign frame_last = h_last && (cnt_v == VW'(V_TOTAL - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_h <= '0;
            cnt_v <= '0;
        end else if (h_last) begin
            cnt_h <= '0;
            cnt_v <= (cnt_v == VW'(V_TOTAL - 1)) ? '0 : cnt_v + 1'b1;
        end else begin
            cnt_h <= cnt_h + 1'b1;
        end
    end

    assign h_act = (cnt_h >= HW'(H_START)) &&
                   (cnt_h <= HW'(H_START + H_VALID - 1));
    assign v_act = (cnt_v >= VW'(V_START)) &&
                   (cnt_v <= VW'(V_START + V_VALID - 1));
    assign px    = cnt_h - HW'(H_START);
    assign py    = cnt_v - VW'(V_START);

    assign pic_x  = (px >= pos_x) && (px <= pos_x + HW'(PIC_W - 1));
    assign pic_y  = (py >= pos_y) && (py <= pos_y + VW'(PIC_H - 1));
    assign in_pic = h_act && v_act && pic_x && pic_y;

    // Row-major offset inside the picture; the product never exceeds PIC_W*PIC_H-1.
    assign addr_c = ADDR_W'(py - pos_y) * ADDR_W'(PIC_W) + ADDR_W'(px - pos_x);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr_hold <= '0;
        end else if (in_pic) begin
            addr_hold <= addr_c;
        end
    end

    assign rom_rd_en = in_pic;
    assign rom_addr  = in_pic ? addr_c : addr_hold;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            vga_de    <= 1'b0;
            in_pic_d  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            hsync     <= (cnt_h < HW'(H_SYNC));
            vsync     <= (cnt_v < VW'(V_SYNC));
            vga_de    <= h_act && v_act;
            in_pic_d  <= in_pic;
            frame_end <= frame_last;
        end
    end

    // ROM q arrives together with the registered sync/de, so the mux stays aligned.
    always_comb begin
        vga_rgb = '0;
        if (in_pic_d) begin
            vga_rgb = rom_data;
        end else if (vga_de) begin
            vga_rgb = BG_COLOR;
        end
    end

`ifdef VGA_PIC_BOUNCE_EN
    logic          dx;
    logic          dy;
    logic [HW+1:0] nx;
    logic [VW+1:0] ny;
    logic          x_hit;
    logic          y_hit;

    // Two guard bits: the top one flags a step below zero.
    always_comb begin
        nx = dx ? {2'b00, pos_x} + (HW+2)'(STEP)
                : {2'b00, pos_x} - (HW+2)'(STEP);
        ny = dy ? {2'b00, pos_y} + (VW+2)'(STEP)
                : {2'b00, pos_y} - (VW+2)'(STEP);
        x_hit = nx[HW+1] || (nx > (HW+2)'(H_VALID - PIC_W));
        y_hit = ny[VW+1] || (ny > (VW+2)'(V_VALID - PIC_H));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pos_x <= '0;
            pos_y <= '0;
            dx    <= 1'b1;
            dy    <= 1'b1;
        end else if (frame_last) begin
            if (x_hit) begin
                dx <= ~dx;
            end else begin
                pos_x <= nx[HW-1:0];
            end
            if (y_hit) begin
                dy <= ~dy;
            end else begin
                pos_y <= ny[VW-1:0];
            end
        end
    end
`else
    assign pos_x = HW'((H_VALID - PIC_W) / 2);
    assign pos_y = VW'((V_VALID - PIC_H) / 2);
`endif

endmodule

// File: tb/tb_vga_pic_bounce.sv
// Randomised bench for vga_pic_bounce on a shrunk raster with a random ROM image.
// A frame-level position table and per-pixel arithmetic give the expected pin values.
module tb_vga_pic_bounce;

    localparam int HS = 4, HB = 3, HV = 16, HF = 2;
    localparam int VS = 2, VB = 2, VV = 12, VF = 1;
    localparam int PW = 5, PH = 4, AW = 5, RW = 16, STEP = 1;
    localparam logic [RW-1:0] BG = 16'hFFFF;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FR = HT * VT;
    localparam int MAXF = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rom_rd_en;
    logic [AW-1:0] rom_addr;
    logic [RW-1:0] rom_data;
    logic          hsync;
    logic          vsync;
    logic          vga_de;
    logic          frame_end;
    logic [RW-1:0] vga_rgb;

    logic [RW-1:0] rom [0:(1<<AW)-1];
    int posx [MAXF];
    int posy [MAXF];
    int vecs = 0;
    int errs = 0;
    int n = 0;
    int last_addr = 0;

    always #10 clk = ~clk;

    vga_pic_bounce #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .PIC_W(PW), .PIC_H(PH), .ADDR_W(AW), .RGB_W(RW),
        .BG_COLOR(BG), .STEP(STEP)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .rom_rd_en(rom_rd_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .hsync(hsync),
        .vsync(vsync),
        .vga_de(vga_de),
        .frame_end(frame_end),
        .vga_rgb(vga_rgb)
    );

    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom[rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    function automatic void model_pix(input int idx,
                                      output logic hs, output logic vs,
                                      output logic de, output logic fe,
                                      output logic ip, output int addr);
        int h, v, f, px, py;
        h  = idx % HT;
        v  = (idx / HT) % VT;
        f  = idx / FR;
        hs = h < HS;
        vs = v < VS;
        de = (h >= HS + HB) && (h < HS + HB + HV) &&
             (v >= VS + VB) && (v < VS + VB + VV);
        fe = (h == HT - 1) && (v == VT - 1);
        px = h - (HS + HB);
        py = v - (VS + VB);
        ip = de && px >= posx[f] && px < posx[f] + PW &&
             py >= posy[f] && py < posy[f] + PH;
        addr = ip ? (py - posy[f]) * PW + (px - posx[f]) : 0;
    endfunction

    task automatic build_positions();
        int x, y, dx, dy, nx, ny;
`ifdef VGA_PIC_BOUNCE_EN
        x = 0; y = 0; dx = 1; dy = 1;
`else
        x = (HV - PW) / 2; y = (VV - PH) / 2; dx = 0; dy = 0;
`endif
        for (int f = 0; f < MAXF; f++) begin
            posx[f] = x;
            posy[f] = y;
            nx = x + dx * STEP;
            ny = y + dy * STEP;
            if (nx < 0 || nx > HV - PW) dx = -dx; else x = nx;
            if (ny < 0 || ny > VV - PH) dy = -dy; else y = ny;
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_hsync"}, hsync, 0);
        check({pfx, "_vsync"}, vsync, 0);
        check({pfx, "_de"}, vga_de, 0);
        check({pfx, "_fend"}, frame_end, 0);
        check({pfx, "_rden"}, rom_rd_en, 0);
        check({pfx, "_addr"}, rom_addr, 0);
        check({pfx, "_rgb"}, vga_rgb, 0);
    endtask

    task automatic run_cycles(input int k);
        logic hs, vs, de, fe, ip, ipn, x0, x1, x2, x3;
        int a, an;
        logic [RW-1:0] exp_rgb;
        repeat (k) begin
            @(posedge clk);
            #5;
            n++;
            model_pix(n - 1, hs, vs, de, fe, ip, a);
            exp_rgb = ip ? rom[a] : (de ? BG : '0);
            check("hsync", hsync, hs);
            check("vsync", vsync, vs);
            check("de", vga_de, de);
            check("frame_end", frame_end, fe);
            check("rgb", vga_rgb, exp_rgb);
            model_pix(n, x0, x1, x2, x3, ipn, an);
            check("rd_en", rom_rd_en, ipn);
            check("addr", rom_addr, ipn ? an : last_addr);
            if (ipn) last_addr = an;
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        n = 0;
        last_addr = 0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom[i] = RW'($urandom);
        build_positions();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #5;
        check_zero("reset");
        release_reset();
        run_cycles(2 * FR + $urandom_range(FR - 1, 50));
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #5;
        check_zero("rst_hold");
        release_reset();
        run_cycles(30 * FR + 10);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
